// File: rtl/dac_playback.sv
// Frame-based DAC playback: hunts for a sync byte, reads a 16-bit length header,
// then streams the payload from a standard-mode FIFO onto a registered DAC bus.
module dac_playback #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int          MAX_LEN   = 1024,
    parameter logic [7:0] IDLE_CODE = 8'h80
) (
    input  logic       clk_32,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] fifo_dout,
    input  logic       fifo_empty,
    output logic       fifo_rd_en,
    output logic [7:0] dac_data,
    output logic       dac_valid,
    output logic       frame_done,
    output logic       frame_err,
    output logic       underrun,
    output logic [7:0] drop_cnt,
    output logic       busy
);

    // state   | meaning
    // IDLE    | stopped, waiting for start
    // HUNT    | reading bytes until SYNC_BYTE is seen
    // LEN_H   | reading length high byte
    // LEN_L   | reading length low byte, range check
    // PAYLOAD | streaming LEN bytes to the DAC
    // DONE    | one-cycle end-of-frame
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HUNT    = 3'd1;
    localparam logic [2:0] S_LEN_H   = 3'd2;
    localparam logic [2:0] S_LEN_L   = 3'd3;
    localparam logic [2:0] S_PAYLOAD = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic [15:0] MAX_LEN16 = 16'(MAX_LEN);

    logic [2:0]  state;
    logic        inflight;
    logic        pend;
    logic        start_q;
    logic [7:0]  len_h;
    logic [10:0] req_left;
    logic [10:0] rcv_left;
    logic [15:0] len_full;
    logic        len_ok;
    logic        hdr_state;

    assign hdr_state = (state == S_HUNT) || (state == S_LEN_H) || (state == S_LEN_L);
    assign len_full  = {len_h, fifo_dout};
    assign len_ok    = (len_full != 16'd0) && (len_full <= MAX_LEN16);
    assign busy      = (state != S_IDLE);

    // Header reads are one-at-a-time; payload reads are pipelined up to the frame length.
    always_comb begin
        fifo_rd_en = 1'b0;
        if (start) begin
            if (hdr_state)
                fifo_rd_en = !fifo_empty && !inflight;
            else if (state == S_PAYLOAD)
                fifo_rd_en = !fifo_empty && (req_left != 11'd0);
        end
    end

    always_ff @(posedge clk_32 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            inflight   <= 1'b0;
            pend       <= 1'b0;
            start_q    <= 1'b0;
            len_h      <= 8'd0;
            req_left   <= 11'd0;
            rcv_left   <= 11'd0;
            dac_data   <= IDLE_CODE;
            dac_valid  <= 1'b0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            underrun   <= 1'b0;
            drop_cnt   <= 8'd0;
        end else begin
            start_q    <= start;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            dac_valid  <= 1'b0;
            dac_data   <= IDLE_CODE;
            if (start && !start_q)
                underrun <= 1'b0;

            if (!start) begin
                state    <= S_IDLE;
                inflight <= 1'b0;
                pend     <= 1'b0;
                req_left <= 11'd0;
                rcv_left <= 11'd0;
            end else begin
                case (state)
                    S_IDLE: state <= S_HUNT;

                    S_HUNT, S_LEN_H, S_LEN_L: begin
                        inflight <= fifo_rd_en;
                        if (inflight) begin
                            if (state == S_HUNT) begin
                                if (fifo_dout == SYNC_BYTE)
                                    state <= S_LEN_H;
                                else if (drop_cnt != 8'hFF)
                                    drop_cnt <= drop_cnt + 8'd1;
                            end else if (state == S_LEN_H) begin
                                len_h <= fifo_dout;
                                state <= S_LEN_L;
                            end else if (len_ok) begin
                                req_left <= len_full[10:0];
                                rcv_left <= len_full[10:0];
                                state    <= S_PAYLOAD;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= S_HUNT;
                            end
                        end
                    end

                    S_PAYLOAD: begin
                        pend <= fifo_rd_en;
                        if (fifo_rd_en)
                            req_left <= req_left - 11'd1;
                        if (fifo_empty && (req_left != 11'd0))
                            underrun <= 1'b1;
                        // DONE is entered on the edge that presents the last byte.
                        if (pend) begin
                            dac_data  <= fifo_dout;
                            dac_valid <= 1'b1;
                            rcv_left  <= rcv_left - 11'd1;
                            if (rcv_left == 11'd1) begin
                                state      <= S_DONE;
                                frame_done <= 1'b1;
                            end
                        end
                    end

                    S_DONE: begin
                        pend  <= 1'b0;
                        state <= S_HUNT;
                    end

                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dac_playback.sv
// Directed bench for dac_playback: FIFO model, output monitor, hand-computed expectations.
module tb_dac_playback;

    logic       clk_32 = 1'b0;
    logic       rst_n  = 1'b0;
    logic       start  = 1'b0;
    logic [7:0] fifo_dout = 8'd0;
    logic       fifo_empty;
    logic       fifo_rd_en;
    logic [7:0] dac_data;
    logic       dac_valid;
    logic       frame_done;
    logic       frame_err;
    logic       underrun;
    logic [7:0] drop_cnt;
    logic       busy;

    dac_playback dut (
        .clk_32     (clk_32),
        .rst_n      (rst_n),
        .start      (start),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_rd_en (fifo_rd_en),
        .dac_data   (dac_data),
        .dac_valid  (dac_valid),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .underrun   (underrun),
        .drop_cnt   (drop_cnt),
        .busy       (busy)
    );

    always #5 clk_32 = ~clk_32;

    // FIFO model: standard mode, data appears the cycle after a read
    logic [7:0] mem [0:4095];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int rd_cnt = 0;
    int cyc    = 0;
    int pcyc [0:4095];
    bit flush  = 1'b0;

    assign fifo_empty = (wr_ptr == rd_ptr);

    always @(posedge clk_32) begin
        if (flush)
            rd_ptr <= wr_ptr;
        else if (fifo_rd_en && !fifo_empty) begin
            fifo_dout    <= mem[rd_ptr % 4096];
            pcyc[rd_cnt] <= cyc;
            rd_cnt       <= rd_cnt + 1;
            rd_ptr       <= rd_ptr + 1;
        end
        cyc <= cyc + 1;
    end

    // Output monitor
    logic [7:0] samp [0:2047];
    int vcyc [0:2047];
    int vn = 0, dn = 0, en = 0, dcyc = 0, run = 0, last_run = 0, idle_bad = 0;

    always @(negedge clk_32) begin
        if (dac_valid) begin
            samp[vn] = dac_data;
            vcyc[vn] = cyc;
            vn++;
            run++;
        end else begin
            if (run > 0) last_run = run;
            run = 0;
            if (dac_data != 8'h80) idle_bad++;
        end
        if (frame_done) begin
            dn++;
            dcyc = cyc;
        end
        if (frame_err) en++;
    end

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk_32);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr % 4096] = b;
        wr_ptr++;
    endtask

    function automatic int get_cnt(input int sel);
        if (sel == 0) return dn;
        if (sel == 1) return en;
        return vn;
    endfunction

    // sel: 0=frame_done pulses, 1=frame_err pulses, 2=valid samples
    task automatic wait_for(input string tag, input int sel, input int target, input int limit);
        int k = 0;
        while (get_cnt(sel) < target && k < limit) begin
            tick();
            k++;
        end
        chk(tag, int'(get_cnt(sel) >= target), 1);
    endtask

    int bv, br, bd, be, bdrop, r_at, mism;
    logic [7:0] nom [7] = '{8'hA5, 8'h00, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44};
    logic [7:0] gar [6] = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h01, 8'h7E};
    logic [7:0] ill [6] = '{8'hA5, 8'h00, 8'h00, 8'hA5, 8'h04, 8'h01};
    logic [7:0] unr [5] = '{8'hA5, 8'h00, 8'h03, 8'h10, 8'h20};

    task automatic snap();
        bv = vn; br = rd_cnt; bd = dn; be = en; bdrop = int'(drop_cnt);
    endtask

    initial begin
        // Reset with start high and data available: nothing may move
        push(8'h00);
        start = 1'b1;
        repeat (3) tick();
        chk("rst_rd_en", fifo_rd_en, 0);
        chk("rst_dac_data", dac_data, 8'h80);
        chk("rst_dac_valid", dac_valid, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_underrun", underrun, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        chk("rst_busy", busy, 0);
        start = 1'b0;
        rst_n = 1'b1;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        chk("idle_busy", busy, 0);

        // Nominal 4-byte frame
        snap();
        foreach (nom[i]) push(nom[i]);
        start = 1'b1;
        wait_for("nom_timeout", 0, bd + 1, 200);
        repeat (3) tick();
        chk("nom_valid_cnt", vn - bv, 4);
        chk("nom_s0", samp[bv], 8'h11);
        chk("nom_s1", samp[bv + 1], 8'h22);
        chk("nom_s2", samp[bv + 2], 8'h33);
        chk("nom_s3", samp[bv + 3], 8'h44);
        chk("nom_contig", vcyc[bv + 3] - vcyc[bv], 3);
        chk("nom_latency", vcyc[bv] - pcyc[br + 3], 2);
        chk("nom_done_align", dcyc, vcyc[bv + 3]);
        chk("nom_reads", rd_cnt - br, 7);
        chk("nom_done_cnt", dn - bd, 1);
        chk("nom_drops", int'(drop_cnt) - bdrop, 0);
        chk("nom_busy_hunt", busy, 1);
        start = 1'b0;
        tick();
        chk("nom_busy_idle", busy, 0);

        // Garbage before sync, LEN=1
        snap();
        foreach (gar[i]) push(gar[i]);
        start = 1'b1;
        wait_for("gar_timeout", 0, bd + 1, 200);
        repeat (3) tick();
        chk("gar_drops", int'(drop_cnt) - bdrop, 2);
        chk("gar_valid_cnt", vn - bv, 1);
        chk("gar_s0", samp[bv], 8'h7E);
        chk("gar_done_cnt", dn - bd, 1);
        start = 1'b0;
        tick();

        // LEN=0 and LEN=1025
        snap();
        foreach (ill[i]) push(ill[i]);
        start = 1'b1;
        wait_for("ill_timeout", 1, be + 2, 200);
        repeat (4) tick();
        chk("ill_err_cnt", en - be, 2);
        chk("ill_valid_cnt", vn - bv, 0);
        chk("ill_reads", rd_cnt - br, 6);
        chk("ill_done_cnt", dn - bd, 0);
        chk("ill_busy", busy, 1);
        start = 1'b0;
        tick();

        // Underrun mid-payload
        snap();
        foreach (unr[i]) push(unr[i]);
        start = 1'b1;
        wait_for("unr_timeout1", 2, bv + 2, 200);
        repeat (5) tick();
        chk("unr_flag", underrun, 1);
        chk("unr_valid_mid", vn - bv, 2);
        push(8'h30);
        wait_for("unr_timeout2", 0, bd + 1, 200);
        repeat (2) tick();
        chk("unr_valid_cnt", vn - bv, 3);
        chk("unr_s0", samp[bv], 8'h10);
        chk("unr_s1", samp[bv + 1], 8'h20);
        chk("unr_s2", samp[bv + 2], 8'h30);
        chk("unr_gap", int'(vcyc[bv + 2] - vcyc[bv + 1] > 1), 1);
        chk("unr_done_cnt", dn - bd, 1);
        chk("unr_reads", rd_cnt - br, 6);
        start = 1'b0;
        tick();
        chk("unr_sticky", underrun, 1);
        start = 1'b1;
        tick();
        chk("unr_clear", underrun, 0);
        start = 1'b0;
        tick();

        // Abort after 2 of 8 payload bytes
        snap();
        push(8'hA5); push(8'h00); push(8'h08);
        for (int i = 1; i <= 8; i++) push(8'(i));
        start = 1'b1;
        wait_for("abt_timeout", 2, bv + 2, 200);
        start = 1'b0;
        r_at = rd_cnt;
        tick();
        chk("abt_busy", busy, 0);
        chk("abt_rd_en", fifo_rd_en, 0);
        repeat (5) tick();
        chk("abt_reads_stop", rd_cnt, r_at);
        chk("abt_valid_cnt", vn - bv, 2);
        chk("abt_done_cnt", dn - bd, 0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();

        // Maximum length frame
        snap();
        push(8'hA5); push(8'h04); push(8'h00);
        for (int i = 0; i < 1024; i++) push(8'(i));
        start = 1'b1;
        wait_for("max_timeout", 0, bd + 1, 3000);
        repeat (2) tick();
        chk("max_valid_cnt", vn - bv, 1024);
        chk("max_run", last_run, 1024);
        chk("max_reads", rd_cnt - br, 1027);
        chk("max_done_cnt", dn - bd, 1);
        chk("max_err_cnt", en - be, 0);
        chk("max_underrun", underrun, 0);
        mism = 0;
        for (int i = 0; i < 1024; i++)
            if (samp[bv + i] != 8'(i)) mism++;
        chk("max_data", mism, 0);
        start = 1'b0;
        tick();

        chk("idle_code_hold", idle_bad, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
